// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the MEM stage: accepts one load/store, stalls the pipeline
// for LATENCY cycles, then acks. Optional performance counters are built with `define DMEM_PERF_EN.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        ack_o,
  output logic        stall_o,
  output logic        err_o,
  output logic [31:0] rd_cnt_o,
  output logic [31:0] wr_cnt_o,
  output logic [31:0] stall_cnt_o
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [32:0] LIMIT = 33'(4 * DEPTH_WORDS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            wr_q, wr_d;
  logic            both_q, both_d;
  logic            fault_q, fault_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [31:0]     data_q, data_d;
  logic            ack_q, ack_d;
  logic            err_q, err_d;
  logic            stall_s;
  logic            req_s;
  logic            enter_done_s;
  logic            commit_wr_s;
  logic            load_s;

  logic [31:0]     mem_q [DEPTH_WORDS];

  assign req_s = MemRead_i | MemWrite_i;

  // Next-state logic; the accepted request is captured in the IDLE->BUSY/DONE transition
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    both_d  = both_q;
    fault_d = fault_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    stall_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_s) begin
          stall_s = 1'b1;
          wr_d    = MemWrite_i;
          both_d  = MemRead_i & MemWrite_i;
          fault_d = (addr_i[1:0] != 2'b00) || ({1'b0, addr_i} >= LIMIT);
          idx_d   = addr_i[AW+1:2];
          wdata_d = data_i;
          cnt_d   = CW'(LATENCY - 1);
          state_d = (LATENCY == 1) ? S_DONE : S_BUSY;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BUSY: begin
        stall_s = 1'b1;
        if (cnt_q == CW'(1)) begin
          state_d = S_DONE;
        end else begin
          cnt_d   = cnt_q - CW'(1);
          state_d = S_BUSY;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // The memory effect uses the _d copies so a LATENCY=1 accept sees its own request
  assign enter_done_s = (state_d == S_DONE);
  assign commit_wr_s  = enter_done_s && wr_d && !fault_d;
  assign load_s       = enter_done_s && !wr_d;

  // Registered response values, updated only on the edge entering DONE
  always_comb begin
    ack_d  = enter_done_s;
    err_d  = enter_done_s && (fault_d || both_d);
    data_d = data_q;
    if (load_s) begin
      if (fault_d) begin
        data_d = 32'd0;
      end else begin
        data_d = mem_q[idx_d];
      end
    end else begin
      data_d = data_q;
    end
  end

  // Control and response registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      both_q  <= 1'b0;
      fault_q <= 1'b0;
      idx_q   <= '0;
      wdata_q <= 32'd0;
      data_q  <= 32'd0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      both_q  <= both_d;
      fault_q <= fault_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      data_q  <= data_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  // Storage array; not cleared by reset, and a reset on the commit edge drops the write
  always_ff @(posedge clk_i) begin
    if (!rst_i && commit_wr_s) begin
      mem_q[idx_d] <= wdata_d;
    end
  end

  assign data_o  = data_q;
  assign ack_o   = ack_q;
  assign err_o   = err_q;
  assign stall_o = stall_s;

`ifdef DMEM_PERF_EN
  logic [31:0] rd_cnt_q, wr_cnt_q, stall_cnt_q;

  // Performance counters; faulting accesses (including read+write) are not counted
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_cnt_q    <= 32'd0;
      wr_cnt_q    <= 32'd0;
      stall_cnt_q <= 32'd0;
    end else begin
      if (load_s && !fault_d) begin
        rd_cnt_q <= rd_cnt_q + 32'd1;
      end
      if (commit_wr_s && !both_d) begin
        wr_cnt_q <= wr_cnt_q + 32'd1;
      end
      if (stall_s) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end

  assign rd_cnt_o    = rd_cnt_q;
  assign wr_cnt_o    = wr_cnt_q;
  assign stall_cnt_o = stall_cnt_q;
`else
  assign rd_cnt_o    = 32'd0;
  assign wr_cnt_o    = 32'd0;
  assign stall_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a LATENCY=4 instance for the main sequence and a
// LATENCY=1 instance for the single-stall / no-re-accept case.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  always #5 clk = ~clk;

  logic        mr4 = 1'b0, mw4 = 1'b0;
  logic [31:0] a4 = 32'd0, dw4 = 32'd0;
  logic [31:0] do4, rc4, wc4, sc4;
  logic        ack4, stall4, err4;

  logic        mr1 = 1'b0, mw1 = 1'b0;
  logic [31:0] a1 = 32'd0, dw1 = 32'd0;
  logic [31:0] do1, rc1, wc1, sc1;
  logic        ack1, stall1, err1;

  int n_pass = 0;
  int n_total = 0;

`ifdef DMEM_PERF_EN
  localparam logic [31:0] EXP_RD = 32'd3;
  localparam logic [31:0] EXP_WR = 32'd2;
  localparam logic [31:0] EXP_ST = 32'd20;
`else
  localparam logic [31:0] EXP_RD = 32'd0;
  localparam logic [31:0] EXP_WR = 32'd0;
  localparam logic [31:0] EXP_ST = 32'd0;
`endif

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(4)) u_dut4 (
    .clk_i(clk), .rst_i(rst), .MemRead_i(mr4), .MemWrite_i(mw4),
    .addr_i(a4), .data_i(dw4), .data_o(do4), .ack_o(ack4), .stall_o(stall4),
    .err_o(err4), .rd_cnt_o(rc4), .wr_cnt_o(wc4), .stall_cnt_o(sc4)
  );

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .MemRead_i(mr1), .MemWrite_i(mw1),
    .addr_i(a1), .data_i(dw1), .data_o(do1), .ack_o(ack1), .stall_o(stall1),
    .err_o(err1), .rd_cnt_o(rc1), .wr_cnt_o(wc1), .stall_cnt_o(sc1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One LATENCY=4 access held on the inputs until its ack; inputs drop after the ack cycle
  task automatic acc4(input string tag, input logic rd, input logic wr, input logic [31:0] a,
                      input logic [31:0] d, input logic exp_err, input logic chk_data,
                      input logic [31:0] exp_data);
    mr4 = rd; mw4 = wr; a4 = a; dw4 = d;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk({tag, "_stall"}, {31'd0, stall4}, 32'd1);
      step();
    end
    @(negedge clk);
    chk({tag, "_ack"}, {31'd0, ack4}, 32'd1);
    chk({tag, "_ackstall"}, {31'd0, stall4}, 32'd0);
    chk({tag, "_err"}, {31'd0, err4}, {31'd0, exp_err});
    if (chk_data) chk({tag, "_data"}, do4, exp_data);
    step();
    mr4 = 1'b0; mw4 = 1'b0; a4 = 32'd0; dw4 = 32'd0;
  endtask

  initial begin
    // reset
    step();
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ack", {31'd0, ack4}, 32'd0);
    chk("rst_stall", {31'd0, stall4}, 32'd0);
    chk("rst_err", {31'd0, err4}, 32'd0);
    chk("rst_data", do4, 32'd0);
    chk("rst_rdcnt", rc4, 32'd0);
    chk("rst_stcnt", sc4, 32'd0);
    step();

    // store then load, back to back
    acc4("st10", 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0, 32'd0);
    acc4("ld10", 1'b1, 1'b0, 32'h10, 32'd0, 1'b0, 1'b1, 32'hDEADBEEF);

    // faults: misaligned load, out-of-range load, misaligned store must not write
    acc4("ld13", 1'b1, 1'b0, 32'h13, 32'd0, 1'b1, 1'b1, 32'd0);
    acc4("ld400", 1'b1, 1'b0, 32'h400, 32'd0, 1'b1, 1'b1, 32'd0);
    acc4("st11", 1'b0, 1'b1, 32'h11, 32'h12345678, 1'b1, 1'b0, 32'd0);
    acc4("ld10b", 1'b1, 1'b0, 32'h10, 32'd0, 1'b0, 1'b1, 32'hDEADBEEF);

    // read+write together: store with error
    acc4("rw20", 1'b1, 1'b1, 32'h20, 32'd5, 1'b1, 1'b0, 32'd0);
    acc4("ld20", 1'b1, 1'b0, 32'h20, 32'd0, 1'b0, 1'b1, 32'd5);

    // reset during the last BUSY cycle of a store aborts it
    acc4("st30", 1'b0, 1'b1, 32'h30, 32'hA5A5A5A5, 1'b0, 1'b0, 32'd0);
    mw4 = 1'b1; a4 = 32'h30; dw4 = 32'h11111111;
    @(negedge clk);
    chk("abort_stall0", {31'd0, stall4}, 32'd1);
    step();
    step();
    step();
    rst = 1'b1; mw4 = 1'b0; a4 = 32'd0; dw4 = 32'd0;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("abort_stall", {31'd0, stall4}, 32'd0);
    chk("abort_ack", {31'd0, ack4}, 32'd0);
    chk("abort_data", do4, 32'd0);
    step();

    // 3 loads + 2 stores after reset for the performance counters
    acc4("ld30", 1'b1, 1'b0, 32'h30, 32'd0, 1'b0, 1'b1, 32'hA5A5A5A5);
    acc4("st40", 1'b0, 1'b1, 32'h40, 32'd7, 1'b0, 1'b0, 32'd0);
    acc4("ld40", 1'b1, 1'b0, 32'h40, 32'd0, 1'b0, 1'b1, 32'd7);
    acc4("st44", 1'b0, 1'b1, 32'h44, 32'd9, 1'b0, 1'b0, 32'd0);
    acc4("ld44", 1'b1, 1'b0, 32'h44, 32'd0, 1'b0, 1'b1, 32'd9);
    @(negedge clk);
    chk("perf_rd", rc4, EXP_RD);
    chk("perf_wr", wc4, EXP_WR);
    chk("perf_stall", sc4, EXP_ST);
    step();

    // LATENCY=1: store then load, each held for two cycles
    mw1 = 1'b1; a1 = 32'h8; dw1 = 32'hCAFEF00D;
    @(negedge clk);
    chk("l1_st_stall", {31'd0, stall1}, 32'd1);
    chk("l1_st_ack0", {31'd0, ack1}, 32'd0);
    step();
    @(negedge clk);
    chk("l1_st_ack", {31'd0, ack1}, 32'd1);
    chk("l1_st_done_stall", {31'd0, stall1}, 32'd0);
    chk("l1_st_err", {31'd0, err1}, 32'd0);
    step();
    mw1 = 1'b0; mr1 = 1'b1; a1 = 32'h8; dw1 = 32'd0;
    @(negedge clk);
    chk("l1_ld_stall", {31'd0, stall1}, 32'd1);
    step();
    @(negedge clk);
    chk("l1_ld_ack", {31'd0, ack1}, 32'd1);
    chk("l1_ld_done_stall", {31'd0, stall1}, 32'd0);
    chk("l1_ld_data", do1, 32'hCAFEF00D);
    step();
    mr1 = 1'b0; a1 = 32'd0;
    @(negedge clk);
    chk("l1_noreacc_ack", {31'd0, ack1}, 32'd0);
    chk("l1_noreacc_stall", {31'd0, stall1}, 32'd0);
    chk("l1_hold_data", do1, 32'hCAFEF00D);
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
